// File: rtl/mont_cmd_sequencer.sv
// Hardware command sequencer for the dual-core Montgomery wrapper.
// Issues commands 0..4, streams operands, collects both products.
module mont_cmd_sequencer #(
  parameter int unsigned WORD_LEN       = 512,
  parameter int unsigned CMD_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [WORD_LEN-1:0] req_a1,
  input  logic [WORD_LEN-1:0] req_b1,
  input  logic [WORD_LEN-1:0] req_m1,
  input  logic [WORD_LEN-1:0] req_a2,
  input  logic [WORD_LEN-1:0] req_b2,
  input  logic [WORD_LEN-1:0] req_m2,
  output logic [CMD_W-1:0]    port1_din,
  output logic                port1_valid,
  input  logic                port1_read,
  input  logic                port2_valid,
  output logic                port2_read,
  output logic [WORD_LEN-1:0] bram_din1,
  output logic [WORD_LEN-1:0] bram_din2,
  output logic                bram_din_valid,
  input  logic [WORD_LEN-1:0] bram_dout1,
  input  logic [WORD_LEN-1:0] bram_dout2,
  input  logic                bram_dout1_valid,
  input  logic                bram_dout2_valid,
  output logic                bram_dout_read,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [WORD_LEN-1:0] res1,
  output logic [WORD_LEN-1:0] res2,
  output logic                busy,
  output logic                error
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_LOAD,
    S_WAIT_DONE, S_WRITE_WAIT, S_RESULT
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t state, state_nx;
  logic [2:0] k;
  logic [CNT_W-1:0] cnt;
  logic cap_flag, done_flag;
  logic cap_now, done_now;
  logic accept, abort, waiting, tmo_hit;
  logic [WORD_LEN-1:0] a1, b1, m1, a2, b2, m2;

  assign busy    = (state != S_IDLE);
  assign waiting = (state == S_ISSUE) ||
                   (state == S_WAIT_DONE) ||
                   (state == S_WRITE_WAIT);
  assign tmo_hit = waiting && (cnt == CNT_LAST);

  // Next state and per-state handshake strobes.
  always_comb begin
    state_nx       = state;
    req_ready      = 1'b0;
    port1_valid    = 1'b0;
    port1_din      = '0;
    port2_read     = 1'b0;
    bram_din_valid = 1'b0;
    bram_dout_read = 1'b0;
    res_valid      = 1'b0;
    accept         = 1'b0;
    abort          = 1'b0;
    cap_now        = 1'b0;
    done_now       = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept   = 1'b1;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        port1_valid = 1'b1;
        port1_din   = CMD_W'(k);
        if (port1_read) begin
          if (k < 3'd3)       state_nx = S_LOAD;
          else if (k == 3'd3) state_nx = S_WAIT_DONE;
          else                state_nx = S_WRITE_WAIT;
        end else if (tmo_hit) begin
          abort    = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_LOAD: begin
        bram_din_valid = 1'b1;
        state_nx       = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (port2_valid) begin
          port2_read = 1'b1;
          state_nx   = S_ISSUE;
        end else if (tmo_hit) begin
          abort    = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_WRITE_WAIT: begin
        cap_now  = !cap_flag && bram_dout1_valid &&
                   bram_dout2_valid;
        done_now = !done_flag && port2_valid;
        bram_dout_read = cap_now;
        port2_read     = done_now;
        if ((cap_flag || cap_now) &&
            (done_flag || done_now)) begin
          state_nx = S_RESULT;
        end else if (tmo_hit) begin
          abort    = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, command index, timeout counter, write-phase flags, error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      k         <= '0;
      cnt       <= '0;
      cap_flag  <= 1'b0;
      done_flag <= 1'b0;
      error     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state) cnt <= '0;
      else if (waiting)      cnt <= cnt + 1'b1;
      if (accept) k <= '0;
      else if (state == S_WAIT_DONE && port2_valid)
        k <= k + 3'd1;
      if (state != S_WRITE_WAIT) begin
        cap_flag  <= 1'b0;
        done_flag <= 1'b0;
      end else begin
        if (cap_now)  cap_flag  <= 1'b1;
        if (done_now) done_flag <= 1'b1;
      end
      if (accept)     error <= 1'b0;
      else if (abort) error <= 1'b1;
    end
  end

  // Operand capture on accept and operand bus update per load command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a1 <= '0; b1 <= '0; m1 <= '0;
      a2 <= '0; b2 <= '0; m2 <= '0;
      bram_din1 <= '0;
      bram_din2 <= '0;
    end else begin
      if (accept) begin
        a1 <= req_a1; b1 <= req_b1; m1 <= req_m1;
        a2 <= req_a2; b2 <= req_b2; m2 <= req_m2;
      end
      if (state == S_ISSUE && port1_read && k < 3'd3) begin
        case (k)
          3'd0:    begin bram_din1 <= a1; bram_din2 <= a2; end
          3'd1:    begin bram_din1 <= b1; bram_din2 <= b2; end
          default: begin bram_din1 <= m1; bram_din2 <= m2; end
        endcase
      end
    end
  end

  // Result latch when both cores present their products.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res1 <= '0;
      res2 <= '0;
    end else if (cap_now) begin
      res1 <= bram_dout1;
      res2 <= bram_dout2;
    end
  end

endmodule

// File: doc/mont_cmd_sequencer.md
Name: mont_cmd_sequencer

Overview:
- Upstream driver for montgomery_wrapper; replaces the manual task-based command flow with hardware sequencing.
- Accepts one dual-core request (A1/B1/M1, A2/B2/M2) per transaction.
- Issues commands 0..4 over port1, feeds operands over the BRAM-in bus, consumes port2 completion and the BRAM-out result.
- Returns both 512-bit products on a valid/ready result port.

Parameters:
- WORD_LEN, 512, operand/result width.
- CMD_W, 32, port1 command width.
- TIMEOUT_CYCLES, 65535, max cycles spent waiting in any wait state before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer idle; request accepted when req_valid & req_ready.
- req_a1, req_b1, req_m1, req_a2, req_b2, req_m2  in  WORD_LEN each  operands.
- port1_din  out  CMD_W  command word.
- port1_valid  out  1  command valid.
- port1_read  in  1  wrapper accepted command.
- port2_valid  in  1  wrapper command done.
- port2_read  out  1  done acknowledge.
- bram_din1, bram_din2  out  WORD_LEN  operand to core 1/2.
- bram_din_valid  out  1  operand strobe.
- bram_dout1, bram_dout2  in  WORD_LEN  result from core 1/2.
- bram_dout1_valid, bram_dout2_valid  in  1  result present.
- bram_dout_read  out  1  result consumed.
- res_valid  out  1  results available.
- res_ready  in  1  consumer takes results.
- res1, res2  out  WORD_LEN  products.
- busy  out  1  transaction in progress.
- error  out  1  sticky timeout flag.

Behaviour:
- Clocking/reset: one clock clk; reset is asynchronous and active-high. On reset:
  - all outputs 0 except req_ready=1;
  - FSM to IDLE; operand and result registers cleared.
- Operand capture: all six operands registered on accept; req inputs are ignored afterwards. Accept clears error; busy=1 from the next cycle until return to IDLE.
- FSM states: IDLE, ISSUE, LOAD, WAIT_DONE, WRITE_WAIT, RESULT. Command index k runs 0..4.
- ISSUE:
  - port1_valid=1, port1_din=k (zero-extended); held stable until port1_read=1 is sampled.
  - Next cycle: port1_valid=0.
  - Then k<3 -> LOAD; k=3 -> WAIT_DONE; k=4 -> WRITE_WAIT.
- LOAD:
  - bram_din_valid=1 for exactly one cycle; bram_din1/2 = A/B/M pair for k=0/1/2.
  - Data bus holds its value afterwards.
  - -> WAIT_DONE.
- WAIT_DONE:
  - On the first cycle port2_valid=1, drive port2_read=1 for exactly one cycle.
  - Then k++ and -> ISSUE (k<3) or ISSUE with k=3 -> 4 after MULTIPLY.
- WRITE_WAIT: two independent flags, captured and done.
  - When bram_dout1_valid & bram_dout2_valid: latch res1/res2, pulse bram_dout_read for one cycle, set captured.
  - When port2_valid: pulse port2_read for one cycle, set done.
  - The two events may arrive in either order or in the same cycle; in the same cycle both pulses fire.
  - When both flags are set -> RESULT.
- RESULT:
  - res_valid=1; res1/res2 held stable until res_ready=1.
  - Same cycle -> IDLE; res_valid=0 next cycle.
- Timeout:
  - A counter resets on every state change and increments in ISSUE, WAIT_DONE and WRITE_WAIT.
  - Reaching TIMEOUT_CYCLES sets error=1, drops port1_valid, and moves to IDLE without res_valid.
- req_valid while busy: ignored, since req_ready=0.
- Reset mid-operation: immediate asynchronous return to reset values; no further port pulses.
- Latency, zero-wait wrapper: an accept-to-res_valid bound is fixed by the state sequence (5 ISSUE + 3 LOAD + 4 WAIT_DONE + WRITE_WAIT, each at least 1 cycle). No bubbles beyond one cycle per state.

Test Plan:
1. Full transaction with behavioural wrapper model, A1=93839e5e…31dd, B1=84145032…ec2a, M1=dc40c654…6875 and the second vector set:
   - port1 sequence must be exactly 0,1,2,3,4;
   - operands are written in order A, B, M;
   - res1=7bd8d21c…2a74 and res2=92c8540b…a186, each with one res_valid assertion.
2. port1_read delayed 7 cycles on each command -> port1_valid and port1_din stay constant for all 7 cycles; exactly one bram_din_valid pulse per load command.
3. WRITE phase ordering, in separate runs:
   - bram_dout valid 3 cycles before port2_valid;
   - bram_dout valid 3 cycles after port2_valid;
   - both in the same cycle.
   Each run -> one bram_dout_read pulse and one port2_read pulse, with correct results.
4. res_ready held low 10 cycles with req_valid=1 -> res_valid held, res1/res2 stable, req_ready=0; the new request is accepted only after res_ready.
5. Wrapper never asserts port2_valid after MULTIPLY, with TIMEOUT_CYCLES=16 -> error=1 exactly 16 cycles after entering WAIT_DONE, then IDLE with req_ready=1. The next accepted request clears error.
6. Assert reset during WAIT_DONE for the MULTIPLY command -> all outputs 0 and req_ready=1 without waiting for a clock edge; a subsequent transaction completes correctly.
